// File: rtl/ctrl_pipeline_unit_if.sv
// ============================================================================
// ctrl_pipeline_unit_if : IF/ID fields in, staged control bundles out.
// Optional ports under ILLEGAL_OP_TRAP_EN.  Rev 2.0
// ============================================================================
`default_nettype none

interface ctrl_pipeline_if #(
   parameter int REG_ADDR_W = 5
);
   logic                  hold;
   logic                  ex_flush;
   logic                  id_valid;
   logic [6:0]            id_opcode;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic [REG_ADDR_W-1:0] id_rd;

   logic                  stall_id;

   logic                  ex_valid;
   logic [2:0]            ex_immSel;
   logic [1:0]            ex_ALUop;
   logic                  ex_ALUSrcA;
   logic                  ex_ALUSrcB;
   logic                  ex_branch;
   logic                  ex_jump;
   logic                  ex_jalr;
   logic                  ex_memRead;
   logic                  ex_memWrite;
   logic [1:0]            ex_wbSel;
   logic                  ex_regWrite;
   logic [REG_ADDR_W-1:0] ex_rd;

   logic                  mem_valid;
   logic                  mem_memRead;
   logic                  mem_memWrite;
   logic [1:0]            mem_wbSel;
   logic                  mem_regWrite;
   logic [REG_ADDR_W-1:0] mem_rd;

   logic                  wb_valid;
   logic [1:0]            wb_wbSel;
   logic                  wb_regWrite;
   logic [REG_ADDR_W-1:0] wb_rd;

`ifdef ILLEGAL_OP_TRAP_EN
   logic                  illegal_op;
   logic [6:0]            illegal_opcode;
`endif

   modport slave (
      input  hold, ex_flush, id_valid, id_opcode, id_rs1, id_rs2, id_rd,
      output stall_id,
      output ex_valid, ex_immSel, ex_ALUop, ex_ALUSrcA, ex_ALUSrcB, ex_branch,
             ex_jump, ex_jalr, ex_memRead, ex_memWrite, ex_wbSel, ex_regWrite, ex_rd,
      output mem_valid, mem_memRead, mem_memWrite, mem_wbSel, mem_regWrite, mem_rd,
      output wb_valid, wb_wbSel, wb_regWrite, wb_rd
`ifdef ILLEGAL_OP_TRAP_EN
      , output illegal_op, illegal_opcode
`endif
   );

   modport master (
      output hold, ex_flush, id_valid, id_opcode, id_rs1, id_rs2, id_rd,
      input  stall_id,
      input  ex_valid, ex_immSel, ex_ALUop, ex_ALUSrcA, ex_ALUSrcB, ex_branch,
             ex_jump, ex_jalr, ex_memRead, ex_memWrite, ex_wbSel, ex_regWrite, ex_rd,
      input  mem_valid, mem_memRead, mem_memWrite, mem_wbSel, mem_regWrite, mem_rd,
      input  wb_valid, wb_wbSel, wb_regWrite, wb_rd
`ifdef ILLEGAL_OP_TRAP_EN
      , input illegal_op, illegal_opcode
`endif
   );
endinterface

`default_nettype wire

// File: rtl/ctrl_pipeline_unit.sv
// ============================================================================
// ctrl_pipeline_unit : RV32I main control, ID/EX/MEM/WB bundles, load-use stall,
// flush and hold.  Optional trap: ILLEGAL_OP_TRAP_EN.  Rev 2.0
// ============================================================================
`default_nettype none

module ctrl_pipeline_unit #(
   parameter int REG_ADDR_W    = 5,
   parameter bit HAZARD_DETECT = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   ctrl_pipeline_if.slave bus_io
);

   localparam logic [6:0] c_OP_R     = 7'b0110011;
   localparam logic [6:0] c_OP_IALU  = 7'b0010011;
   localparam logic [6:0] c_OP_LW    = 7'b0000011;
   localparam logic [6:0] c_OP_SW    = 7'b0100011;
   localparam logic [6:0] c_OP_BR    = 7'b1100011;
   localparam logic [6:0] c_OP_JAL   = 7'b1101111;
   localparam logic [6:0] c_OP_JALR  = 7'b1100111;
   localparam logic [6:0] c_OP_LUI   = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

   localparam logic [2:0] c_IMM_I = 3'b000;
   localparam logic [2:0] c_IMM_S = 3'b001;
   localparam logic [2:0] c_IMM_B = 3'b010;
   localparam logic [2:0] c_IMM_J = 3'b011;
   localparam logic [2:0] c_IMM_U = 3'b100;

   localparam logic [1:0] c_ALU_SUB = 2'b01;
   localparam logic [1:0] c_ALU_R   = 2'b10;
   localparam logic [1:0] c_ALU_I   = 2'b11;

   localparam logic [1:0] c_WB_MEM = 2'b01;
   localparam logic [1:0] c_WB_PC4 = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [2:0]            imm_sel;
      logic [1:0]            alu_op;
      logic                  src_a;
      logic                  src_b;
      logic                  branch;
      logic                  jump;
      logic                  jalr;
      logic                  mem_read;
      logic                  mem_write;
      logic [1:0]            wb_sel;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
   } idex_t;

   typedef struct packed {
      logic                  valid;
      logic                  mem_read;
      logic                  mem_write;
      logic [1:0]            wb_sel;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
   } exmem_t;

   typedef struct packed {
      logic                  valid;
      logic [1:0]            wb_sel;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
   } memwb_t;

   idex_t  dec;
   idex_t  ex_d, ex_q;
   exmem_t mem_d, mem_q;
   memwb_t wb_d, wb_q;
   logic   known;
   logic   uses_rs2;
   logic   hazard;
   logic   stall;

   always_comb begin
      dec      = '0;
      known    = 1'b1;
      uses_rs2 = 1'b0;
      case (bus_io.id_opcode)
         c_OP_R: begin
            dec.alu_op    = c_ALU_R;
            dec.reg_write = 1'b1;
            uses_rs2      = 1'b1;
         end
         c_OP_IALU: begin
            dec.imm_sel   = c_IMM_I;
            dec.alu_op    = c_ALU_I;
            dec.src_b     = 1'b1;
            dec.reg_write = 1'b1;
         end
         c_OP_LW: begin
            dec.imm_sel   = c_IMM_I;
            dec.src_b     = 1'b1;
            dec.mem_read  = 1'b1;
            dec.wb_sel    = c_WB_MEM;
            dec.reg_write = 1'b1;
         end
         c_OP_SW: begin
            dec.imm_sel   = c_IMM_S;
            dec.src_b     = 1'b1;
            dec.mem_write = 1'b1;
            uses_rs2      = 1'b1;
         end
         c_OP_BR: begin
            dec.imm_sel   = c_IMM_B;
            dec.alu_op    = c_ALU_SUB;
            dec.branch    = 1'b1;
            uses_rs2      = 1'b1;
         end
         c_OP_JAL: begin
            dec.imm_sel   = c_IMM_J;
            dec.src_a     = 1'b1;
            dec.jump      = 1'b1;
            dec.wb_sel    = c_WB_PC4;
            dec.reg_write = 1'b1;
         end
         c_OP_JALR: begin
            dec.imm_sel   = c_IMM_I;
            dec.src_b     = 1'b1;
            dec.jump      = 1'b1;
            dec.jalr      = 1'b1;
            dec.wb_sel    = c_WB_PC4;
            dec.reg_write = 1'b1;
         end
         c_OP_LUI: begin
            dec.imm_sel   = c_IMM_U;
            dec.src_b     = 1'b1;
            dec.reg_write = 1'b1;
         end
         c_OP_AUIPC: begin
            dec.imm_sel   = c_IMM_U;
            dec.src_a     = 1'b1;
            dec.src_b     = 1'b1;
            dec.reg_write = 1'b1;
         end
         default: known = 1'b0;
      endcase
      dec.rd = bus_io.id_rd;
      // x0 is never a real write target
      if (bus_io.id_rd == '0) begin
         dec.reg_write = 1'b0;
      end
      if (!bus_io.id_valid || !known) begin
         dec = '0;
      end else begin
         dec.valid = 1'b1;
      end
   end

   if (HAZARD_DETECT) begin : g_hazard_on
      assign hazard = bus_io.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                      ((ex_q.rd == bus_io.id_rs1) || (uses_rs2 && (ex_q.rd == bus_io.id_rs2)));
   end else begin : g_hazard_off
      assign hazard = 1'b0;
   end

   // Flush and hold both suppress the stall: the ID instruction is either dead or frozen.
   assign stall = hazard && !rst && !bus_io.hold && !bus_io.ex_flush;

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!bus_io.hold) begin
         ex_d            = (bus_io.ex_flush || stall) ? '0 : dec;
         mem_d.valid     = ex_q.valid;
         mem_d.mem_read  = ex_q.mem_read;
         mem_d.mem_write = ex_q.mem_write;
         mem_d.wb_sel    = ex_q.wb_sel;
         mem_d.reg_write = ex_q.reg_write;
         mem_d.rd        = ex_q.rd;
         wb_d.valid      = mem_q.valid;
         wb_d.wb_sel     = mem_q.wb_sel;
         wb_d.reg_write  = mem_q.reg_write;
         wb_d.rd         = mem_q.rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign bus_io.stall_id     = stall;
   assign bus_io.ex_valid     = ex_q.valid;
   assign bus_io.ex_immSel    = ex_q.imm_sel;
   assign bus_io.ex_ALUop     = ex_q.alu_op;
   assign bus_io.ex_ALUSrcA   = ex_q.src_a;
   assign bus_io.ex_ALUSrcB   = ex_q.src_b;
   assign bus_io.ex_branch    = ex_q.branch;
   assign bus_io.ex_jump      = ex_q.jump;
   assign bus_io.ex_jalr      = ex_q.jalr;
   assign bus_io.ex_memRead   = ex_q.mem_read;
   assign bus_io.ex_memWrite  = ex_q.mem_write;
   assign bus_io.ex_wbSel     = ex_q.wb_sel;
   assign bus_io.ex_regWrite  = ex_q.reg_write;
   assign bus_io.ex_rd        = ex_q.rd;
   assign bus_io.mem_valid    = mem_q.valid;
   assign bus_io.mem_memRead  = mem_q.mem_read;
   assign bus_io.mem_memWrite = mem_q.mem_write;
   assign bus_io.mem_wbSel    = mem_q.wb_sel;
   assign bus_io.mem_regWrite = mem_q.reg_write;
   assign bus_io.mem_rd       = mem_q.rd;
   assign bus_io.wb_valid     = wb_q.valid;
   assign bus_io.wb_wbSel     = wb_q.wb_sel;
   assign bus_io.wb_regWrite  = wb_q.reg_write;
   assign bus_io.wb_rd        = wb_q.rd;

`ifdef ILLEGAL_OP_TRAP_EN
   logic       illegal_q;
   logic [6:0] illegal_opcode_q;

   // Sticky first-offender capture; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q        <= 1'b0;
         illegal_opcode_q <= '0;
      end else if (!bus_io.hold && !bus_io.ex_flush && bus_io.id_valid && !known && !illegal_q) begin
         illegal_q        <= 1'b1;
         illegal_opcode_q <= bus_io.id_opcode;
      end
   end

   assign bus_io.illegal_op     = illegal_q;
   assign bus_io.illegal_opcode = illegal_opcode_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipeline_unit.sv
// ============================================================================
// tb_ctrl_pipeline_unit : directed stimulus, spec-table model, per-cycle compare.
// Rev 2.0
// ============================================================================
`default_nettype none

module tb_ctrl_pipeline_unit;

   localparam logic [6:0] c_R     = 7'b0110011;
   localparam logic [6:0] c_IALU  = 7'b0010011;
   localparam logic [6:0] c_LW    = 7'b0000011;
   localparam logic [6:0] c_SW    = 7'b0100011;
   localparam logic [6:0] c_BR    = 7'b1100011;
   localparam logic [6:0] c_JAL   = 7'b1101111;
   localparam logic [6:0] c_JALR  = 7'b1100111;
   localparam logic [6:0] c_LUI   = 7'b0110111;
   localparam logic [6:0] c_AUIPC = 7'b0010111;
   localparam logic [6:0] c_SYS   = 7'b1110011;
   localparam logic [6:0] c_FENCE = 7'b0001111;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ctrl_pipeline_if #(.REG_ADDR_W(5)) bus();

   ctrl_pipeline_unit #(
      .REG_ADDR_W   (5),
      .HAZARD_DETECT(1'b1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus_io(bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   typedef struct packed {
      logic       valid;
      logic [2:0] imm;
      logic [1:0] alu;
      logic       a, b, br, j, jr, mr, mw;
      logic [1:0] wb;
      logic       rw;
      logic [4:0] rd;
   } bnd_t;

   bnd_t m_ex, m_mem, m_wb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Control table, row = {imm, alu, A, B, br, j, jr, mr, mw, wb, rw}
   function automatic bnd_t model_dec(input logic v, input logic [6:0] op, input logic [4:0] rd);
      logic [14:0] ctl;
      bit          ok;
      bnd_t        r;
      ok = 1'b1;
      case (op)
         c_R:     ctl = 15'b000_10_0_0_0_0_0_0_0_00_1;
         c_IALU:  ctl = 15'b000_11_0_1_0_0_0_0_0_00_1;
         c_LW:    ctl = 15'b000_00_0_1_0_0_0_1_0_01_1;
         c_SW:    ctl = 15'b001_00_0_1_0_0_0_0_1_00_0;
         c_BR:    ctl = 15'b010_01_0_0_1_0_0_0_0_00_0;
         c_JAL:   ctl = 15'b011_00_1_0_0_1_0_0_0_10_1;
         c_JALR:  ctl = 15'b000_00_0_1_0_1_1_0_0_10_1;
         c_LUI:   ctl = 15'b100_00_0_1_0_0_0_0_0_00_1;
         c_AUIPC: ctl = 15'b100_00_1_1_0_0_0_0_0_00_1;
         default: begin ctl = '0; ok = 1'b0; end
      endcase
      if (!v || !ok) return '0;
      r = {1'b1, ctl, rd};
      if (rd == 5'd0) r.rw = 1'b0;
      return r;
   endfunction

   function automatic logic model_stall();
      if (rst || bus.hold || bus.ex_flush || !bus.id_valid) return 1'b0;
      if (!(m_ex.valid && m_ex.mr && m_ex.rd != 5'd0)) return 1'b0;
      if (m_ex.rd == bus.id_rs1) return 1'b1;
      if (m_ex.rd == bus.id_rs2 &&
          (bus.id_opcode == c_R || bus.id_opcode == c_SW || bus.id_opcode == c_BR)) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ex  = '0;
         m_mem = '0;
         m_wb  = '0;
      end else if (!bus.hold) begin
         bit s;
         s     = model_stall();
         m_wb  = m_mem;
         m_mem = m_ex;
         m_ex  = (bus.ex_flush || s) ? '0 : model_dec(bus.id_valid, bus.id_opcode, bus.id_rd);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ex_bundle", 32'({bus.ex_valid, bus.ex_immSel, bus.ex_ALUop, bus.ex_ALUSrcA,
             bus.ex_ALUSrcB, bus.ex_branch, bus.ex_jump, bus.ex_jalr, bus.ex_memRead,
             bus.ex_memWrite, bus.ex_wbSel, bus.ex_regWrite, bus.ex_rd}), 32'(m_ex));
         chk("mem_bundle", 32'({bus.mem_valid, bus.mem_memRead, bus.mem_memWrite, bus.mem_wbSel,
             bus.mem_regWrite, bus.mem_rd}),
             32'({m_mem.valid, m_mem.mr, m_mem.mw, m_mem.wb, m_mem.rw, m_mem.rd}));
         chk("wb_bundle", 32'({bus.wb_valid, bus.wb_wbSel, bus.wb_regWrite, bus.wb_rd}),
             32'({m_wb.valid, m_wb.wb, m_wb.rw, m_wb.rd}));
         chk("stall_id", 32'(bus.stall_id), 32'(model_stall()));
      end
   end

   task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
      bus.id_valid  = v;
      bus.id_opcode = op;
      bus.id_rd     = rd;
      bus.id_rs1    = rs1;
      bus.id_rs2    = rs2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ex"}, 32'({bus.ex_valid, bus.ex_immSel, bus.ex_ALUop, bus.ex_ALUSrcA,
          bus.ex_ALUSrcB, bus.ex_branch, bus.ex_jump, bus.ex_jalr, bus.ex_memRead,
          bus.ex_memWrite, bus.ex_wbSel, bus.ex_regWrite, bus.ex_rd}), 32'd0);
      chk({tag, "_mem"}, 32'({bus.mem_valid, bus.mem_memRead, bus.mem_memWrite, bus.mem_wbSel,
          bus.mem_regWrite, bus.mem_rd}), 32'd0);
      chk({tag, "_wb"}, 32'({bus.wb_valid, bus.wb_wbSel, bus.wb_regWrite, bus.wb_rd}), 32'd0);
      chk({tag, "_stall"}, 32'(bus.stall_id), 32'd0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.hold     = 1'b0;
      bus.ex_flush = 1'b0;
      drive(1'b1, c_LW, 5'd5, 5'd1, 5'd0);

      // reset during an LW stream
      tick();
      chk_all_zero("reset");
      cmp_en = 1'b1;
      tick();
      rst = 1'b0;

      // first ADD x3,x1,x2
      drive(1'b1, c_R, 5'd3, 5'd1, 5'd2);
      tick();
      chk("add_ex_aluop", 32'(bus.ex_ALUop), 32'd2);
      chk("add_ex_valid", 32'(bus.ex_valid), 32'd1);
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick();
      tick();
      chk("add_wb_regwrite", 32'(bus.wb_regWrite), 32'd1);
      chk("add_wb_rd", 32'(bus.wb_rd), 32'd3);

      // load-use: LW x5 ; ADD x6,x5,x7
      drive(1'b1, c_LW, 5'd5, 5'd1, 5'd0);
      tick();
      drive(1'b1, c_R, 5'd6, 5'd5, 5'd7);
      #1 chk("lu_stall_on", 32'(bus.stall_id), 32'd1);
      tick();
      chk("lu_ex_bubble", 32'(bus.ex_valid), 32'd0);
      chk("lu_mem_lw", 32'(bus.mem_memRead), 32'd1);
      #1 chk("lu_stall_off", 32'(bus.stall_id), 32'd0);
      tick();
      chk("lu_add_ex_rd", 32'(bus.ex_rd), 32'd6);
      chk("lu_add_ex_valid", 32'(bus.ex_valid), 32'd1);

      // LW x5 ; ADDI x6,x0 with rs2 field 5 : no stall
      drive(1'b1, c_LW, 5'd5, 5'd1, 5'd0);
      tick();
      drive(1'b1, c_IALU, 5'd6, 5'd0, 5'd5);
      #1 chk("addi_no_stall", 32'(bus.stall_id), 32'd0);
      tick();
      chk("addi_ex_aluop", 32'(bus.ex_ALUop), 32'd3);

      // LW x5 ; SW rs2=x5 : stall via rs2
      drive(1'b1, c_LW, 5'd5, 5'd1, 5'd0);
      tick();
      drive(1'b1, c_SW, 5'd4, 5'd2, 5'd5);
      #1 chk("sw_rs2_stall", 32'(bus.stall_id), 32'd1);
      tick();
      tick();

      // flush coinciding with load-use
      drive(1'b1, c_LW, 5'd5, 5'd1, 5'd0);
      tick();
      drive(1'b1, c_R, 5'd6, 5'd5, 5'd7);
      bus.ex_flush = 1'b1;
      #1 chk("flush_stall_off", 32'(bus.stall_id), 32'd0);
      tick();
      bus.ex_flush = 1'b0;
      chk("flush_ex_bubble", 32'(bus.ex_valid), 32'd0);
      chk("flush_mem_lw", 32'(bus.mem_memRead), 32'd1);
      chk("flush_mem_rd", 32'(bus.mem_rd), 32'd5);

      // hold for 3 cycles with ADDI x1 / SW / LW x2 in WB/MEM/EX
      drive(1'b1, c_IALU, 5'd1, 5'd0, 5'd0);
      tick();
      drive(1'b1, c_SW, 5'd8, 5'd1, 5'd1);
      tick();
      drive(1'b1, c_LW, 5'd2, 5'd1, 5'd0);
      tick();
      drive(1'b1, c_R, 5'd9, 5'd2, 5'd0);
      bus.hold = 1'b1;
      #1 chk("hold_stall_off", 32'(bus.stall_id), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_ex_rd", 32'(bus.ex_rd), 32'd2);
         chk("hold_mem_sw", 32'(bus.mem_memWrite), 32'd1);
         chk("hold_wb_rd", 32'(bus.wb_rd), 32'd1);
      end
      bus.hold = 1'b0;
      #1 chk("post_hold_stall", 32'(bus.stall_id), 32'd1);
      tick();
      chk("post_hold_mem_rd", 32'(bus.mem_rd), 32'd2);
      chk("post_hold_wb_sw", 32'(bus.wb_regWrite), 32'd0);
      tick();
      chk("post_hold_ex_rd", 32'(bus.ex_rd), 32'd9);
      chk("post_hold_wb_lw", 32'(bus.wb_wbSel), 32'd1);

      // decode sweep
      drive(1'b1, c_JALR, 5'd1, 5'd0, 5'd0);
      tick();
      chk("jalr_flags", 32'({bus.ex_jump, bus.ex_jalr, bus.ex_wbSel}), 32'b1110);
      drive(1'b1, c_AUIPC, 5'd4, 5'd0, 5'd0);
      tick();
      chk("auipc_imm", 32'(bus.ex_immSel), 32'd4);
      chk("auipc_srca", 32'(bus.ex_ALUSrcA), 32'd1);
      drive(1'b1, c_JAL, 5'd0, 5'd0, 5'd0);
      tick();
      chk("jal_rd0_rw", 32'(bus.ex_regWrite), 32'd0);
      chk("jal_rd0_jump", 32'(bus.ex_jump), 32'd1);
      drive(1'b1, c_FENCE, 5'd3, 5'd0, 5'd0);
      tick();
      chk("fence_bubble", 32'(bus.ex_valid), 32'd0);
      drive(1'b1, c_SYS, 5'd3, 5'd0, 5'd0);
      tick();
      chk("sys_bubble", 32'(bus.ex_valid), 32'd0);
      drive(1'b1, c_LUI, 5'd7, 5'd0, 5'd0);
      tick();
      drive(1'b1, c_BR, 5'd0, 5'd1, 5'd2);
      tick();
      chk("beq_imm_alu", 32'({bus.ex_immSel, bus.ex_ALUop, bus.ex_branch}), 32'b010011);
      drive(1'b0, c_R, 5'd3, 5'd0, 5'd0);
      tick();
`ifdef ILLEGAL_OP_TRAP_EN
      chk("trap_flag", 32'(bus.illegal_op), 32'd1);
      chk("trap_opcode", 32'(bus.illegal_opcode), 32'(c_FENCE));
`endif

      // reset mid-stream discards in-flight bundles
      drive(1'b1, c_LW, 5'd5, 5'd1, 5'd0);
      tick();
      drive(1'b1, c_R, 5'd6, 5'd1, 5'd2);
      rst = 1'b1;
      tick();
      chk_all_zero("midreset");
`ifdef ILLEGAL_OP_TRAP_EN
      chk("trap_cleared", 32'(bus.illegal_op), 32'd0);
`endif
      rst = 1'b0;
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ctrl_pipeline_unit.md
Name: ctrl_pipeline_unit

Overview:
- Second-generation main control for the 5-stage RV32I pipeline. Decodes the ID-stage opcode into a widened control bundle, covering R, I-ALU, LW, SW, BEQ-class, JAL, JALR, LUI and AUIPC.
- Carries the bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use hazard detection, bubble insertion, branch flush and global hold, none of which the first-generation combinational decoder had.
- Sits between the IF/ID register and the datapath stage registers.

Parameters:
- REG_ADDR_W, 5, register-index width for rs1/rs2/rd.
- HAZARD_DETECT, 1, 1 = load-use detection active; 0 = stall_id tied 0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global freeze (memory wait); all stage registers keep their value.
- ex_flush  in  1  branch/jump redirect resolved in EX this cycle.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  7  instr[6:0].
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  IF/ID register fields.
- stall_id  out  1  hold PC and IF/ID (load-use).
- ex_valid, ex_immSel[2:0], ex_ALUop[1:0], ex_ALUSrcA, ex_ALUSrcB, ex_branch, ex_jump, ex_jalr, ex_memRead, ex_memWrite, ex_wbSel[1:0], ex_regWrite, ex_rd  out  ID/EX bundle.
- mem_valid, mem_memRead, mem_memWrite, mem_wbSel[1:0], mem_regWrite, mem_rd  out  EX/MEM bundle.
- wb_valid, wb_wbSel[1:0], wb_regWrite, wb_rd  out  MEM/WB bundle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: every stage register and every output clears to 0, including stall_id. A reset asserted mid-operation discards all in-flight bundles on the next edge.
- Decode is combinational in ID and registered into ID/EX. A bundle reaches the EX, MEM and WB outputs 1, 2 and 3 cycles after issue.
- immSel encoding: I=000, S=001, B=010, J=011, U=100.
- ALUop encoding: 00 = add, 01 = sub/compare, 10 = R funct, 11 = I funct.
- ALUSrcA: 1 = PC (AUIPC, JAL).
- ALUSrcB: 1 = immediate.
- wbSel encoding: 00 = ALU, 01 = mem, 10 = PC+4.
- Decode table:
  - R (0110011): ALUop=10, regWrite=1.
  - I-ALU (0010011): imm I, ALUop=11, SrcB=1, regWrite=1.
  - LW (0000011): imm I, SrcB=1, memRead=1, wbSel=01, regWrite=1.
  - SW (0100011): imm S, SrcB=1, memWrite=1.
  - BEQ-class (1100011): imm B, ALUop=01, branch=1.
  - JAL (1101111): imm J, SrcA=1, jump=1, wbSel=10, regWrite=1.
  - JALR (1100111): imm I, SrcB=1, jump=1, jalr=1, wbSel=10, regWrite=1.
  - LUI (0110111): imm U, SrcB=1, regWrite=1. The datapath forces rs1=x0.
  - AUIPC (0010111): imm U, SrcA=1, SrcB=1, regWrite=1.
  - Any other opcode, or id_valid=0: bubble (all controls 0, valid=0).
- regWrite is forced to 0 whenever rd==0.
- Load-use detection: stall_id=1 when all of the following hold:
  - HAZARD_DETECT=1, id_valid=1, ex_valid=1, ex_memRead=1, ex_rd!=0;
  - and ex_rd==id_rs1, or ex_rd==id_rs2 with the ID opcode being R, SW or BEQ-class.
- On a stall: ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
- On ex_flush=1: ID/EX loads a bubble and stall_id is forced to 0. The instruction in EX still advances to MEM.
- Priority: rst > hold > ex_flush > stall > normal.
- While hold=1: no register changes and stall_id=0. The upstream EX logic keeps ex_flush asserted for as long as hold stays high.
- Stall repeats at most once per load. After one bubble, ex_memRead=0, so the stall releases.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Extra outputs: illegal_op (1-bit, sticky) and illegal_opcode[6:0].
  - On the first valid, unflushed, unheld unsupported opcode, illegal_op is set and the opcode is captured one cycle later.
  - Both are cleared only by rst. Later illegal opcodes do not overwrite the capture.
- Not defined: unsupported opcodes silently become bubbles and the ports are absent.

Test Plan:
- Reset: assert rst for 2 cycles during an LW stream -> all outputs 0 on the first edge. The first post-reset ADD reaches ex_ALUop=10 one cycle after issue and wb_regWrite=1 three cycles after issue.
- Load-use: LW x5 followed by ADD x6,x5,x7 -> stall_id=1 for exactly 1 cycle and ex_valid=0 for one cycle. ADD enters EX one cycle late. LW followed by ADDI x6,x0,x5 with rs2 field=5 -> no stall.
- Flush vs stall: ex_flush=1 in the same cycle as a load-use condition -> stall_id=0, ID/EX bubble, and mem_memRead=1 for the LW already in EX.
- Hold: hold=1 for 3 cycles mid-stream -> all ex_*/mem_*/wb_* frozen. Pipeline resumes with no lost or duplicated bundle.
- Decode sweep: JALR rd=1 -> ex_jump=1, ex_jalr=1, ex_wbSel=10. AUIPC -> ex_immSel=100, SrcA=1. JAL rd=0 -> ex_regWrite=0. Opcode 1110011 -> bubble.
- ILLEGAL_OP_TRAP_EN: opcode 0001111 then 1110011 -> illegal_op=1 and illegal_opcode=0001111, held until rst.
